// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared types and default widths for the NES memory arbiter.
//   state_t : arbiter FSM states (IDLE, REQ)
//   owner_t : which requester owns the backend transaction
//   slot_t  : one pending request at the core's default widths
package nes_mem_pkg;
   localparam int DEF_ADDR_W = 22;
   localparam int DEF_DATA_W = 8;
   typedef enum logic {IDLE, REQ} state_t;
   typedef enum logic {OWN_CPU, OWN_PPU} owner_t;
   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] addr;
      logic                  we;
      logic [DEF_DATA_W-1:0] wdata;
   } slot_t;
endpackage

// File: rtl/nes_mem_slot.sv
// nes_mem_slot: one requester's pending-request slot.
//   clk, reset (sync, active-low)
//   load, load_addr, load_we, load_wdata : strobe and its request
//   servicing : the arbiter is currently running this slot's transaction
//   complete  : that transaction is acked this cycle
//   valid, addr, we, wdata : slot contents
//   overrun   : sticky, a strobe overwrote a request that was never issued
module nes_mem_slot
   import nes_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              load_we,
   input  logic [DATA_W-1:0] load_wdata,
   input  logic              servicing,
   input  logic              complete,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic              we,
   output logic [DATA_W-1:0] wdata,
   output logic              overrun
);
   // Set when a new request lands while this slot's previous one is in flight,
   // so the completion must not clear valid for the queued request.
   logic requeued;
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid    <= 1'b0;
         requeued <= 1'b0;
         addr     <= '0;
         we       <= 1'b0;
         wdata    <= '0;
         overrun  <= 1'b0;
      end else begin
         if (load) begin
            addr  <= load_addr;
            we    <= load_we;
            wdata <= load_wdata;
         end
         valid    <= load | (valid & ~(complete & ~requeued));
         requeued <= complete ? 1'b0 : (requeued | (load & servicing));
         overrun  <= overrun | (load & valid & ~servicing);
      end
   end
endmodule

// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter: serialises NES CPU/PPU memory strobes onto one req/ack backend.
//   clk, reset (sync, active-low)
//   memory_addr, memory_read_cpu, memory_write, memory_read_ppu, memory_dout : core strobes
//   memory_din_cpu, memory_din_ppu : last read data per requester, held
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata : backend handshake
//   busy : work pending; err_overlap, err_overrun[1:0] : sticky error flags
module nes_mem_arbiter
   import nes_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] memory_addr,
   input  logic              memory_read_cpu,
   input  logic              memory_write,
   input  logic              memory_read_ppu,
   input  logic [DATA_W-1:0] memory_dout,
   output logic [DATA_W-1:0] memory_din_cpu,
   output logic [DATA_W-1:0] memory_din_ppu,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err_overlap,
   output logic [1:0]        err_overrun
);
   state_t state, state_nxt;
   owner_t owner, sel_owner;
   logic cpu_strobe, ppu_load, overlap;
   logic cpu_serv, ppu_serv, issue, done;
   logic cpu_valid, cpu_we, cpu_ovr, ppu_valid, ppu_we, ppu_ovr;
   logic [ADDR_W-1:0] cpu_addr, ppu_addr, sel_addr;
   logic [DATA_W-1:0] cpu_wdata, ppu_wdata, sel_wdata;
   logic sel_we;

   // A write wins over a simultaneous CPU read; a PPU strobe colliding with
   // any CPU strobe is dropped.
   assign cpu_strobe = memory_read_cpu | memory_write;
   assign ppu_load   = memory_read_ppu & ~cpu_strobe;
   assign overlap    = memory_read_ppu & cpu_strobe;
   assign cpu_serv   = (state == REQ) && (owner == OWN_CPU);
   assign ppu_serv   = (state == REQ) && (owner == OWN_PPU);

   nes_mem_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (cpu_strobe),
      .load_addr  (memory_addr),
      .load_we    (memory_write),
      .load_wdata (memory_dout),
      .servicing  (cpu_serv),
      .complete   (cpu_serv & mem_ack),
      .valid      (cpu_valid),
      .addr       (cpu_addr),
      .we         (cpu_we),
      .wdata      (cpu_wdata),
      .overrun    (cpu_ovr)
   );

   nes_mem_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ppu_slot (
      .clk        (clk),
      .reset      (reset),
      .load       (ppu_load),
      .load_addr  (memory_addr),
      .load_we    (1'b0),
      .load_wdata ('0),
      .servicing  (ppu_serv),
      .complete   (ppu_serv & mem_ack),
      .valid      (ppu_valid),
      .addr       (ppu_addr),
      .we         (ppu_we),
      .wdata      (ppu_wdata),
      .overrun    (ppu_ovr)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = (state == IDLE) ? ((ppu_valid | cpu_valid) ? REQ : IDLE)
                                  : (mem_ack ? IDLE : REQ);
   end

   // PPU has priority whenever its slot is pending.
   always_comb begin
      issue     = (state == IDLE) && (ppu_valid || cpu_valid);
      done      = (state == REQ) && mem_ack;
      sel_owner = ppu_valid ? OWN_PPU : OWN_CPU;
      sel_addr  = ppu_valid ? ppu_addr : cpu_addr;
      sel_we    = ppu_valid ? ppu_we : cpu_we;
      sel_wdata = ppu_valid ? ppu_wdata : cpu_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         owner          <= OWN_CPU;
         memory_din_cpu <= '0;
         memory_din_ppu <= '0;
         err_overlap    <= 1'b0;
      end else begin
         err_overlap <= err_overlap | overlap;
         if (issue) begin
            mem_req   <= 1'b1;
            owner     <= sel_owner;
            mem_addr  <= sel_addr;
            mem_we    <= sel_we;
            mem_wdata <= sel_wdata;
         end else if (done) begin
            mem_req <= 1'b0;
            if (!mem_we && owner == OWN_CPU) memory_din_cpu <= mem_rdata;
            if (!mem_we && owner == OWN_PPU) memory_din_ppu <= mem_rdata;
         end
      end
   end

   assign busy        = cpu_valid | ppu_valid | (state != IDLE);
   assign err_overrun = {ppu_ovr, cpu_ovr};
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb_nes_mem_arbiter: scoreboard bench for nes_mem_arbiter with a latency-programmable backend.
module tb_nes_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [21:0] memory_addr;
   logic        memory_read_cpu, memory_write, memory_read_ppu;
   logic [7:0]  memory_dout, memory_din_cpu, memory_din_ppu;
   logic        mem_req, mem_we, mem_ack;
   logic [21:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        busy, err_overlap;
   logic [1:0]  err_overrun;

   nes_mem_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .memory_addr     (memory_addr),
      .memory_read_cpu (memory_read_cpu),
      .memory_write    (memory_write),
      .memory_read_ppu (memory_read_ppu),
      .memory_dout     (memory_dout),
      .memory_din_cpu  (memory_din_cpu),
      .memory_din_ppu  (memory_din_ppu),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .busy            (busy),
      .err_overlap     (err_overlap),
      .err_overrun     (err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      logic        ppu;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   checks = 0;
   int   failures = 0;
   int   ack_lat = 0;
   int   req_cyc = 0;
   bit   active = 0;
   bit   done_pending = 0;
   logic [7:0] exp_cpu = 8'h00;
   logic [7:0] exp_ppu = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Backend memory contents: 0x012345 holds 0xBB, elsewhere addr[9:2]^0x5C.
   function automatic logic [7:0] bk_data(input logic [21:0] a);
      return (a == 22'h012345) ? 8'hBB : (a[9:2] ^ 8'h5C);
   endfunction

   initial begin
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req) begin
            mem_ack = (req_cyc == ack_lat);
            mem_rdata = mem_ack ? bk_data(mem_addr) : 8'h00;
            req_cyc++;
         end else begin
            mem_ack = 1'b0;
            req_cyc = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            q.delete();
            active = 0;
            done_pending = 0;
            exp_cpu = 8'h00;
            exp_ppu = 8'h00;
         end else if (done_pending) begin
            check("req_drop", {31'd0, mem_req}, 32'd0);
            if (!cur.we) begin
               if (cur.ppu) exp_ppu = cur.rdata;
               else exp_cpu = cur.rdata;
            end
            check("din_cpu", {24'd0, memory_din_cpu}, {24'd0, exp_cpu});
            check("din_ppu", {24'd0, memory_din_ppu}, {24'd0, exp_ppu});
            done_pending = 0;
         end else if (mem_req) begin
            if (!active) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_req: got addr %0h we %0b with no request expected", mem_addr, mem_we);
                  cur = '{mem_addr, mem_we, mem_wdata, 8'h00, 1'b0};
               end else cur = q.pop_front();
               active = 1;
            end
            check("req_addr", {10'd0, mem_addr}, {10'd0, cur.addr});
            check("req_we", {31'd0, mem_we}, {31'd0, cur.we});
            check("req_wdata", {24'd0, mem_wdata}, {24'd0, cur.wdata});
            if (mem_ack) begin
               done_pending = 1;
               active = 0;
            end
         end
      end
   end

   task automatic drive(input logic rc, input logic w, input logic rp, input logic [21:0] a, input logic [7:0] d);
      memory_read_cpu = rc;
      memory_write = w;
      memory_read_ppu = rp;
      memory_addr = a;
      memory_dout = d;
      @(posedge clk);
      #1;
      memory_read_cpu = 1'b0;
      memory_write = 1'b0;
      memory_read_ppu = 1'b0;
      memory_addr = '0;
      memory_dout = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && (q.size() != 0 || active || done_pending); i++) @(posedge clk);
      #1;
      check(name, {31'd0, q.size() == 0 && !active && !done_pending}, 32'd1);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      memory_read_cpu = 1'b0;
      memory_write = 1'b0;
      memory_read_ppu = 1'b0;
      memory_addr = '0;
      memory_dout = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_addr", {10'd0, mem_addr}, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      check("rst_din_cpu", {24'd0, memory_din_cpu}, 32'd0);
      check("rst_din_ppu", {24'd0, memory_din_ppu}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_errs", {29'd0, err_overlap, err_overrun}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);

      // PPU read, ack in first request cycle
      ack_lat = 0;
      q.push_back('{22'h012345, 1'b0, 8'h00, 8'hBB, 1'b1});
      drive(0, 0, 1, 22'h012345, 8'h00);
      @(negedge clk);
      check("t1_req_c1", {31'd0, mem_req}, 32'd0);
      check("t1_busy_c1", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_req_c2", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_req_c3", {31'd0, mem_req}, 32'd0);
      check("t1_din_ppu_c3", {24'd0, memory_din_ppu}, 32'hBB);
      check("t1_din_cpu_c3", {24'd0, memory_din_cpu}, 32'h00);
      @(posedge clk); #1;
      drain("t1_drain");

      // CPU write: no din change
      q.push_back('{22'h000010, 1'b1, 8'h5A, 8'h00, 1'b0});
      drive(0, 1, 0, 22'h000010, 8'h5A);
      drain("t2_drain");

      // CPU then PPU, stalled ack
      ack_lat = 2;
      q.push_back('{22'h000100, 1'b0, 8'h00, 8'h1C, 1'b0});
      q.push_back('{22'h000200, 1'b0, 8'h00, 8'hDC, 1'b1});
      drive(1, 0, 0, 22'h000100, 8'h00);
      drive(0, 0, 1, 22'h000200, 8'h00);
      idle(3);
      @(negedge clk);
      check("t3_gap_c5", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_req_c6", {31'd0, mem_req}, 32'd1);
      check("t3_addr_c6", {10'd0, mem_addr}, 32'h200);
      @(posedge clk); #1;
      drain("t3_drain");

      // CPU strobe while its own request is in flight: queued, no overrun
      ack_lat = 3;
      q.push_back('{22'h00010C, 1'b0, 8'h00, 8'h1F, 1'b0});
      q.push_back('{22'h000110, 1'b0, 8'h00, 8'h18, 1'b0});
      drive(1, 0, 0, 22'h00010C, 8'h00);
      idle(1);
      drive(1, 0, 0, 22'h000110, 8'h00);
      drain("t4_drain");
      check("t4_no_overrun", {30'd0, err_overrun}, 32'd0);

      // Overlap: only CPU issued
      ack_lat = 0;
      q.push_back('{22'h000300, 1'b0, 8'h00, 8'h9C, 1'b0});
      drive(1, 0, 1, 22'h000300, 8'h00);
      drain("t5_drain");
      check("t5_overlap", {31'd0, err_overlap}, 32'd1);

      // Overrun: two CPU reads while PPU owns the backend
      ack_lat = 3;
      q.push_back('{22'h000400, 1'b0, 8'h00, 8'h5C, 1'b1});
      q.push_back('{22'h000108, 1'b0, 8'h00, 8'h1E, 1'b0});
      drive(0, 0, 1, 22'h000400, 8'h00);
      idle(1);
      drive(1, 0, 0, 22'h000104, 8'h00);
      drive(1, 0, 0, 22'h000108, 8'h00);
      drain("t6_drain");
      check("t6_overrun", {30'd0, err_overrun}, 32'd1);
      check("t6_overlap_sticky", {31'd0, err_overlap}, 32'd1);

      // Reset during an outstanding request
      ack_lat = 50;
      q.push_back('{22'h000500, 1'b0, 8'h00, 8'h00, 1'b1});
      drive(0, 0, 1, 22'h000500, 8'h00);
      idle(1);
      @(negedge clk);
      check("t7_req_before", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t7_req", {31'd0, mem_req}, 32'd0);
      check("t7_busy", {31'd0, busy}, 32'd0);
      check("t7_din", {16'd0, memory_din_cpu, memory_din_ppu}, 32'd0);
      check("t7_errs", {29'd0, err_overlap, err_overrun}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(4);
      check("t7_idle_after", {31'd0, mem_req | busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nes_mem_arbiter.md
# nes_mem_arbiter

Serialises the NES core's memory strobes onto one external single-port memory with a req/ack handshake. Requesters are the CPU (read/write) and the PPU (read); the PPU has priority when both are pending. Sits between the `NES` instance and the board SRAM/SDRAM controller. It replaces the direct wiring of `memory_*` to a zero-latency array, so the memory is free to have variable latency.

## Interface
Parameters:
- `ADDR_W`, 22: address width; matches core `memory_addr`.
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-low; 0 = reset.
- `memory_addr`  in  ADDR_W: shared core address, valid in the strobe cycle only.
- `memory_read_cpu`  in  1: one-cycle CPU read strobe.
- `memory_write`  in  1: one-cycle CPU write strobe.
- `memory_read_ppu`  in  1: one-cycle PPU read strobe.
- `memory_dout`  in  DATA_W: CPU write data, valid in the strobe cycle.
- `memory_din_cpu`  out  DATA_W: last CPU read data, held until the next CPU read completes.
- `memory_din_ppu`  out  DATA_W: last PPU read data, held.
- `mem_req`  out  1: backend request.
- `mem_we`  out  1: 1 = write.
- `mem_addr`  out  ADDR_W: backend address.
- `mem_wdata`  out  DATA_W: backend write data.
- `mem_ack`  in  1: backend completion; sampled only while `mem_req`=1.
- `mem_rdata`  in  DATA_W: valid in the `mem_ack` cycle.
- `busy`  out  1: any slot pending or FSM not IDLE.
- `err_overlap`  out  1: sticky; a CPU strobe and a PPU strobe occurred in the same cycle.
- `err_overrun`  out  2: sticky, [0]=CPU, [1]=PPU; a new strobe arrived while that requester's slot was still pending.

## Operation
- Two slots, CPU and PPU. Each slot holds valid, addr, we and wdata. A strobe loads its slot at the end of the strobe cycle.
- CPU slot loads on `memory_read_cpu | memory_write`. If both are high, the write wins and `we`=1.
- Same-cycle CPU and PPU strobes: the CPU slot loads, the PPU strobe is dropped, and `err_overlap` is set.
- Strobe into a pending slot: the slot is overwritten with the new request, the old one is lost, and the matching `err_overrun` bit is set. If the slot is being serviced (FSM in REQ for that requester), the new request is instead queued in the slot and issued after the current transaction completes. `err_overrun` is not set in that case.
- FSM states:
  - IDLE: if the PPU slot is valid, go to REQ with the PPU slot; else if the CPU slot is valid, go to REQ with the CPU slot; else stay in IDLE. Load `mem_addr`, `mem_we` and `mem_wdata` from the chosen slot, set `mem_req`=1, and record the owner.
  - REQ: hold `mem_req` and all `mem_*` outputs stable. When `mem_ack`=1, clear the owner's slot valid (unless it was re-loaded in the same cycle). For a read, capture `mem_rdata` into the owner's `din` register. Then set `mem_req`=0 and go to IDLE.
- Writes never change either `din` register.
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `memory_din_cpu`=0, `memory_din_ppu`=0, `busy`=0, both error flags 0, both slots invalid, FSM=IDLE.
- Reset asserted mid-transaction: at the next edge the block drops `mem_req` and clears everything. The backend must tolerate an abandoned request.

## Timing
- Strobe in cycle 0 → slot valid in cycle 1 → `mem_req`=1 from cycle 2.
- `mem_ack` in cycle k → `din` updated and `mem_req`=0 in cycle k+1.
- Minimum strobe-to-data latency is 3 cycles (ack in cycle 2, data visible in cycle 3).
- Minimum spacing between back-to-back backend requests is one idle cycle: `mem_req` is low for one cycle after each ack.
- `mem_ack` while `mem_req`=0 is ignored.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `nes_mem_pkg` holds:
  - `state_t` {IDLE, REQ}
  - `owner_t` {OWN_CPU, OWN_PPU}
  - `slot_t` struct {valid, addr, we, wdata}
  - default `ADDR_W` / `DATA_W` localparams
- Sub-module `nes_mem_slot`, instantiated twice. It handles load, overwrite, clear-on-complete and overrun detection for one requester.

## Test plan
- PPU read of 0x012345 with ack in the first `mem_req` cycle and `mem_rdata`=0xBB → `mem_req` high in cycle 2 only, `memory_din_ppu`=0xBB from cycle 3, `memory_din_cpu` still 0.
- CPU write of 0x5A to 0x000010 → one request with `mem_we`=1, `mem_wdata`=0x5A, `mem_addr`=0x10. Neither `din` register changes.
- CPU read (0x100) in cycle 0 and PPU read (0x200) in cycle 1, ack held off until cycle 4 → the CPU request issues first and stays stable through the stall. The PPU request issues after one idle cycle, and each `din` register gets its own data.
- `memory_read_cpu` and `memory_read_ppu` in the same cycle → only the CPU request is issued and `err_overlap`=1 and stays set.
- Two CPU reads 1 cycle apart while another request occupies the backend → only the second address is issued and `err_overrun`=2'b01.
- `reset`=0 while `mem_req`=1 → next cycle `mem_req`=0, `busy`=0, `din` registers=0, error flags=0.
